ddr_port1_reader: RTL
=====================

DDR_PORT1_READER -- requirements
Module: ddr_port1_reader

Interface
REQ-001 Parameter BURST_LEN, 32, words per read command (1..64).
REQ-002 Parameter FRAME_WORDS, 307200, 32-bit pixel words per frame (640x480).
REQ-003 Parameter FRAME1_BASE, 30'd5242880, byte base address of frame buffer 1; frame buffer 0 base is 0.
REQ-004 Parameter RD_FIFO_DEPTH, 64, word depth of MCB port-1 read FIFO.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 mem_calib_done  in  1  MCB calibration complete, asynchronous to clk.
REQ-008 frame_start  in  1  one-cycle pulse from display timing: begin reading a new frame.
REQ-009 frame_select  in  1  frame buffer to display (inverse of the writer's memory_frame), sampled on frame_start.
REQ-010 p1_cmd_full  in  1  MCB command FIFO full.
REQ-011 p1_rd_empty  in  1  MCB read FIFO empty.
REQ-012 p1_rd_data  in  32  MCB read FIFO head word (first-word fall-through).
REQ-013 p1_cmd_en  out  1  command strobe.
REQ-014 p1_cmd_instr  out  3  command code; 3'b001 (read) whenever p1_cmd_en is high.
REQ-015 p1_cmd_bl  out  6  burst length minus one.
REQ-016 p1_cmd_byte_addr  out  30  command byte address.
REQ-017 p1_rd_en  out  1  pop MCB read FIFO.
REQ-018 pix_data  out  32  pixel word to display FIFO.
REQ-019 pix_valid  out  1  pix_data valid.
REQ-020 pix_ready  in  1  display FIFO accepts word.
REQ-021 frame_done  out  1  one-cycle pulse after last word of frame delivered.

Function
REQ-022 mem_calib_done passes through a 2-flop synchronizer; S_CALIB holds until synchronized value is 1, then goes to S_IDLE.
REQ-023 States: S_CALIB, S_IDLE, S_CMD, S_FLUSH.
REQ-024 Registers: base (30b), offset (30b byte offset), outstanding (7b words requested, not yet popped), flushing (1b).
REQ-025 S_IDLE -> S_CMD when offset < FRAME_WORDS*4, outstanding + BURST_LEN <= RD_FIFO_DEPTH, !p1_cmd_full, no frame_start this cycle.
REQ-026 S_CMD: p1_cmd_en high exactly one cycle; addr = base + offset; bl = BURST_LEN-1; offset += BURST_LEN*4; outstanding += BURST_LEN; return to S_IDLE.
REQ-027 Final burst truncated: if fewer than BURST_LEN words remain, bl = remaining-1 and outstanding += remaining.
REQ-028 pix_data = p1_rd_data; pix_valid = !p1_rd_empty && !flushing; p1_rd_en = !p1_rd_empty && (flushing || pix_ready); combinational.
REQ-029 outstanding decrements by 1 on each p1_rd_en; simultaneous issue and pop apply net change in the same cycle.
REQ-030 frame_start with outstanding == 0 (any state but S_CALIB): base <= frame_select ? FRAME1_BASE : 0, offset <= 0, next S_IDLE.
REQ-031 frame_start with outstanding > 0: go to S_FLUSH, flushing <= 1, latch frame_select; S_FLUSH pops and discards until outstanding == 0, then loads base/offset as REQ-030, flushing <= 0, S_IDLE.
REQ-032 frame_start during S_CMD: command still issues that cycle; flush covers it.
REQ-033 frame_done pulses once when offset == FRAME_WORDS*4 and outstanding transitions to 0 by a delivered (not flushed) pop.
REQ-034 After frame end, no commands issue until next frame_start.
REQ-035 frame_start in S_CALIB ignored.

Reset
REQ-036 On reset: state S_CALIB, synchronizer 0, base 0, offset FRAME_WORDS*4 (idle until first frame_start), outstanding 0, flushing 0, p1_cmd_en 0, p1_cmd_instr 3'b001, p1_cmd_bl 0, p1_cmd_byte_addr 0, frame_done 0.
REQ-037 Reset mid-burst discards all tracking; MCB port reset is the system's responsibility.

Structure
REQ-038 Shared package holds FRAME_WORDS, FRAME1_BASE, MCB command codes (CMD_WRITE 3'b000, CMD_READ 3'b001), used also by the port-0 writer.
REQ-039 No sub-module; the 2-flop synchronizer is inline.

Verification
REQ-040 Calib held 0 for 100 cycles, then 1 -> no p1_cmd_en before 3 cycles after rise; frame_start then first cmd addr 0, bl 31.
REQ-041 frame_select=1, pix_ready=1, MCB model returns data -> addresses 5242880, +128, +256 ...; exactly 9600 commands; one frame_done after word 307199.
REQ-042 pix_ready=0 permanently -> exactly 2 commands issued (outstanding 64), then none until pops.
REQ-043 BURST_LEN=48, FRAME_WORDS=100 -> bls 47, 47, 3; last addr 384.
REQ-044 frame_start after 3 commands with 40 words unread -> pix_valid stays 0, 40 pops discarded, next cmd addr = new base, no frame_done.
REQ-045 p1_cmd_full held 20 cycles -> no cmd_en during it; issuance resumes next eligible cycle.

Source files
------------

// File: rtl/ddr_port1_reader_pkg.sv
// rtl/ddr_port1_reader_pkg.sv - shared frame-buffer geometry, MCB command codes and reader states
package ddr_port1_reader_pkg;

  localparam int          FRAME_WORDS = 307200;
  localparam logic [29:0] FRAME1_BASE = 30'd5242880;

  localparam logic [2:0]  CMD_WRITE   = 3'b000;
  localparam logic [2:0]  CMD_READ    = 3'b001;

  typedef enum logic [1:0] {
    S_CALIB,
    S_IDLE,
    S_CMD,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/ddr_port1_reader.sv
// rtl/ddr_port1_reader.sv - MCB port-1 frame reader feeding the display pixel FIFO
module ddr_port1_reader #(
  parameter int          BURST_LEN     = 32,
  parameter int          FRAME_WORDS   = ddr_port1_reader_pkg::FRAME_WORDS,
  parameter logic [29:0] FRAME1_BASE   = ddr_port1_reader_pkg::FRAME1_BASE,
  parameter int          RD_FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic        frame_select,
  input  logic        p1_cmd_full,
  input  logic        p1_rd_empty,
  input  logic [31:0] p1_rd_data,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  output logic        p1_rd_en,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done
);
  import ddr_port1_reader_pkg::*;

  localparam logic [29:0] FRAME_BYTES = 30'(FRAME_WORDS * 4);
  localparam logic [6:0]  BURST_W     = 7'(BURST_LEN);
  localparam logic [7:0]  DEPTH_W     = 8'(RD_FIFO_DEPTH);

  state_t      state;
  logic        calib_meta;
  logic        calib_sync;
  logic [29:0] base;
  logic [29:0] offset;
  logic [6:0]  outstanding;
  logic        flushing;
  logic        pending_select;

  logic [29:0] words_left;
  logic [6:0]  burst_words;
  logic [6:0]  outstanding_next;
  logic        can_issue;

  // While flushing, words already requested are popped and dropped so the display never sees them
  assign pix_data     = p1_rd_data;
  assign pix_valid    = !p1_rd_empty && !flushing;
  assign p1_rd_en     = !p1_rd_empty && (flushing || pix_ready);
  assign p1_cmd_instr = CMD_READ;

  always_comb begin
    words_left       = (FRAME_BYTES - offset) >> 2;
    burst_words      = (words_left < 30'(BURST_LEN)) ? words_left[6:0] : BURST_W;
    can_issue        = (state == S_IDLE) && !frame_start && (offset < FRAME_BYTES) && !p1_cmd_full &&
                       (({1'b0, outstanding} + {1'b0, BURST_W}) <= DEPTH_W);
    outstanding_next = outstanding + (can_issue ? burst_words : 7'd0) - {6'd0, p1_rd_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_CALIB;
      calib_meta       <= 1'b0;
      calib_sync       <= 1'b0;
      base             <= '0;
      offset           <= FRAME_BYTES;
      outstanding      <= '0;
      flushing         <= 1'b0;
      pending_select   <= 1'b0;
      p1_cmd_en        <= 1'b0;
      p1_cmd_bl        <= '0;
      p1_cmd_byte_addr <= '0;
      frame_done       <= 1'b0;
    end else begin
      calib_meta  <= mem_calib_done;
      calib_sync  <= calib_meta;
      outstanding <= outstanding_next;
      frame_done  <= (offset == FRAME_BYTES) && (outstanding == 7'd1) && p1_rd_en && !flushing;
      p1_cmd_en   <= 1'b0;
      case (state)
        S_CALIB: if (calib_sync) state <= S_IDLE;
        S_IDLE, S_CMD: begin
          state <= S_IDLE;
          if (frame_start) begin
            if (outstanding == 7'd0) begin
              base   <= frame_select ? FRAME1_BASE : '0;
              offset <= '0;
            end else begin
              flushing       <= 1'b1;
              pending_select <= frame_select;
              state          <= S_FLUSH;
            end
          end else if (can_issue) begin
            // The final burst of a frame is shortened to the words that remain
            p1_cmd_en        <= 1'b1;
            p1_cmd_byte_addr <= base + offset;
            p1_cmd_bl        <= 6'(burst_words - 7'd1);
            offset           <= offset + 30'({burst_words, 2'b00});
            state            <= S_CMD;
          end
        end
        S_FLUSH: begin
          if (frame_start) pending_select <= frame_select;
          if (outstanding == 7'd0) begin
            base     <= (frame_start ? frame_select : pending_select) ? FRAME1_BASE : '0;
            offset   <= '0;
            flushing <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_CALIB;
      endcase
    end
  end

endmodule
